// File: rtl/simulation_pkg.sv
// simulation_pkg: shared FSM encoding and constant helpers for the clocked delay blocks.
package simulation_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/delay_shift_stages.sv
// delay_shift_stages: enabled WIDTH x DEPTH shift register, stage k at bits [k*WIDTH-1:(k-1)*WIDTH].
module delay_shift_stages #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       in,
    output logic [DEPTH*WIDTH-1:0] stages
);

    localparam int N = DEPTH * WIDTH;

    // Truncating {stages, in} drops the oldest stage and lands in at stage 1.
    always_ff @(posedge clock)
        if (!reset_n) stages <= '0;
        else if (enable) stages <= N'({stages, in});

endmodule

// File: rtl/clocked_variable_delay.sv
// clocked_variable_delay: runtime-selectable 0..MAX_DELAY enabled-cycle delay with fill tracking.
// Define CLOCKED_VARIABLE_DELAY_ALL_TAPS_EN to expose every stage on the taps port.
module clocked_variable_delay
    import simulation_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 1,
    parameter int DELAY_BITS    = clog2(MAX_DELAY + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      in,
    input  logic [DELAY_BITS-1:0] delay,
    input  logic                  load_delay,
    output logic [WIDTH-1:0]      out,
    output logic                  valid,
    output logic                  clamped
`ifdef CLOCKED_VARIABLE_DELAY_ALL_TAPS_EN
    ,
    output logic [MAX_DELAY*WIDTH-1:0] taps
`endif
);

    localparam int FW = DELAY_BITS + 1;
    localparam logic [DELAY_BITS-1:0] MAX_D = DELAY_BITS'(MAX_DELAY);
    localparam logic [DELAY_BITS-1:0] DEF_D = DELAY_BITS'(DEFAULT_DELAY);

    logic [MAX_DELAY*WIDTH-1:0] stages;
    logic [WIDTH-1:0]           tap [MAX_DELAY+1];
    logic [DELAY_BITS-1:0]      active_delay, active_next, fill_count, fill_next, new_delay;
    logic [DELAY_BITS:0]        fill_plus;
    logic                       over, restart, reached;
    state_t                     state, state_next;

    delay_shift_stages #(.WIDTH(WIDTH), .DEPTH(MAX_DELAY)) u_stages (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .in      (in),
        .stages  (stages)
    );

`ifdef CLOCKED_VARIABLE_DELAY_ALL_TAPS_EN
    assign taps = stages;
`endif

    assign tap[0] = in;
    for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_tap
        assign tap[k] = stages[k*WIDTH-1 -: WIDTH];
    end

    assign out       = reset_n ? tap[active_delay] : '0;
    assign valid     = (state == RUN);
    assign over      = delay > MAX_D;
    assign new_delay = over ? MAX_D : delay;
    assign restart   = load_delay && (new_delay != active_delay);
    assign fill_plus = {1'b0, fill_count} + FW'(1);
    assign reached   = fill_plus >= {1'b0, active_delay};

    // A restart wins over a simultaneous shift, so that shift is not counted.
    always_comb begin
        state_next  = state;
        fill_next   = fill_count;
        active_next = active_delay;
        if (restart) begin
            active_next = new_delay;
            fill_next   = '0;
            state_next  = (new_delay == '0) ? RUN : FILL;
        end else if (enable && state == FILL) begin
            fill_next  = (fill_count == MAX_D) ? fill_count : fill_plus[DELAY_BITS-1:0];
            state_next = reached ? RUN : FILL;
        end
    end

    always_ff @(posedge clock)
        if (!reset_n) begin
            state        <= (DEFAULT_DELAY == 0) ? RUN : FILL;
            fill_count   <= '0;
            active_delay <= DEF_D;
            clamped      <= 1'b0;
        end else begin
            state        <= state_next;
            fill_count   <= fill_next;
            active_delay <= active_next;
            clamped      <= clamped | (load_delay & over);
        end

endmodule

// File: tb/tb_clocked_variable_delay.sv
// tb_clocked_variable_delay: directed vector table plus random stimulus against a history-queue model.
module tb_clocked_variable_delay;

    localparam int W = 8;
    localparam int MAXD = 16;
    localparam int DB = 5;

    logic          clock = 1'b0;
    logic          reset_n, enable, load_delay;
    logic [W-1:0]  in, out;
    logic [DB-1:0] delay;
    logic          valid, clamped;
`ifdef CLOCKED_VARIABLE_DELAY_ALL_TAPS_EN
    logic [MAXD*W-1:0] taps;
`endif

    clocked_variable_delay #(.WIDTH(W), .MAX_DELAY(MAXD), .DEFAULT_DELAY(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .in         (in),
        .delay      (delay),
        .load_delay (load_delay),
        .out        (out),
        .valid      (valid),
        .clamped    (clamped)
`ifdef CLOCKED_VARIABLE_DELAY_ALL_TAPS_EN
        ,
        .taps       (taps)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rn;
        logic          en;
        logic [W-1:0]  d;
        logic [DB-1:0] dl;
        logic          ld;
        logic [W-1:0]  eo;
        logic          ev;
        logic          ec;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: inputs accepted on enabled edges, newest first, plus enabled edges since last restart.
    logic [W-1:0] hist[$];
    int           m_ad, m_cnt;
    bit           m_cl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_out(input logic rn, input logic [W-1:0] d);
        if (!rn) return '0;
        if (m_ad == 0) return d;
        return hist[m_ad-1];
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < MAXD; i++) hist.push_back('0);
        m_ad = 1;
        m_cnt = 0;
        m_cl = 0;
    endfunction

    function automatic void model_edge(input vec_t v);
        int nw;
        bit rs;
        if (!v.rn) begin
            model_reset();
            return;
        end
        rs = 0;
        nw = (int'(v.dl) > MAXD) ? MAXD : int'(v.dl);
        if (v.ld) begin
            if (int'(v.dl) > MAXD) m_cl = 1;
            if (nw != m_ad) begin
                m_ad = nw;
                m_cnt = 0;
                rs = 1;
            end
        end
        if (v.en) begin
            hist.push_front(v.d);
            void'(hist.pop_back());
            if (!rs && m_cnt < 1000) m_cnt++;
        end
    endfunction

    task automatic step(input vec_t v, input bit use_tab, input int idx);
        reset_n = v.rn;
        enable = v.en;
        in = v.d;
        delay = v.dl;
        load_delay = v.ld;
        #1;
        if (use_tab) begin
            chk($sformatf("tab%0d.out", idx), 32'(out), 32'(v.eo));
            chk($sformatf("tab%0d.valid", idx), 32'(valid), 32'(v.ev));
            chk($sformatf("tab%0d.clamped", idx), 32'(clamped), 32'(v.ec));
        end else begin
            chk($sformatf("rnd%0d.out", idx), 32'(out), 32'(model_out(v.rn, v.d)));
            chk($sformatf("rnd%0d.valid", idx), 32'(valid), 32'(m_ad == 0 || m_cnt >= m_ad));
            chk($sformatf("rnd%0d.clamped", idx), 32'(clamped), 32'(m_cl));
        end
        @(posedge clock);
        model_edge(v);
        #1;
    endtask

    vec_t tab[28];

    initial begin
        vec_t v;
        tab = '{
            '{1'b0, 1'b1, 8'h55, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h00, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h01, 5'd0,  1'b0, 8'h00, 1'b1, 1'b0},
            '{1'b1, 1'b1, 8'h02, 5'd0,  1'b0, 8'h01, 1'b1, 1'b0},
            '{1'b1, 1'b1, 8'h03, 5'd5,  1'b1, 8'h02, 1'b1, 1'b0},
            '{1'b1, 1'b1, 8'h20, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h21, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h22, 5'd0,  1'b0, 8'h01, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h23, 5'd0,  1'b0, 8'h02, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h24, 5'd0,  1'b0, 8'h03, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h25, 5'd0,  1'b0, 8'h20, 1'b1, 1'b0},
            '{1'b1, 1'b1, 8'h26, 5'd20, 1'b1, 8'h21, 1'b1, 1'b0},
            '{1'b1, 1'b1, 8'h27, 5'd0,  1'b0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b1, 8'h00, 5'd0,  1'b1, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b0, 8'h77, 5'd0,  1'b0, 8'h77, 1'b1, 1'b1},
            '{1'b1, 1'b0, 8'h78, 5'd0,  1'b1, 8'h78, 1'b1, 1'b1},
            '{1'b1, 1'b0, 8'h79, 5'd0,  1'b0, 8'h79, 1'b1, 1'b1},
            '{1'b1, 1'b1, 8'h00, 5'd3,  1'b1, 8'h00, 1'b1, 1'b1},
            '{1'b1, 1'b1, 8'h0A, 5'd0,  1'b0, 8'h27, 1'b0, 1'b1},
            '{1'b1, 1'b0, 8'h0B, 5'd0,  1'b0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b0, 8'h0C, 5'd0,  1'b0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b1, 8'h0D, 5'd0,  1'b0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b1, 8'h0E, 5'd0,  1'b0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b0, 8'h0F, 5'd0,  1'b0, 8'h0A, 1'b1, 1'b1},
            '{1'b0, 1'b1, 8'h10, 5'd0,  1'b0, 8'h00, 1'b1, 1'b1},
            '{1'b1, 1'b0, 8'h11, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h12, 5'd0,  1'b0, 8'h00, 1'b0, 1'b0},
            '{1'b1, 1'b1, 8'h13, 5'd0,  1'b0, 8'h12, 1'b1, 1'b0}
        };

        reset_n = 1'b0;
        enable = 1'b0;
        in = '0;
        delay = '0;
        load_delay = 1'b0;
        repeat (2) @(posedge clock);
        model_reset();
        #1;

        for (int i = 0; i < 28; i++) step(tab[i], 1'b1, i);

        for (int i = 0; i < 1500; i++) begin
            v.rn = ($urandom_range(0, 63) != 0);
            v.en = ($urandom_range(0, 3) != 0);
            v.d  = W'($urandom);
            v.dl = DB'($urandom_range(0, 31));
            v.ld = ($urandom_range(0, 7) == 0);
            v.eo = '0;
            v.ev = 1'b0;
            v.ec = 1'b0;
            step(v, 1'b0, i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
